// File: rtl/negf_pipe.sv
`timescale 1ns/1ps
// Elastic float sign unit: pass / negate / abs / negated-abs, with optional canonical-NaN rewrite.
// Latency: LATENCY cycles (0..8). LATENCY=0 is purely combinational.
// Backpressure: per-stage valid/ready, bubbles collapse, ins_ready combinationally follows outs_ready.
//
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-low reset
//   ins, ins_op      operand and sign op (00 pass, 01 neg, 10 abs, 11 neg-abs)
//   ins_valid/ready  input handshake
//   outs             result, held stable while outs_valid & ~outs_ready
//   outs_valid/ready output handshake
module negf_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int LATENCY    = 1,
  parameter bit CANON_NAN  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic [1:0]            ins_op,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int MAN_WIDTH = DATA_WIDTH - 1 - EXP_WIDTH;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_NEG  = 2'b01,
    OP_ABS  = 2'b10,
    OP_NABS = 2'b11
  } sign_op_e;

  // Elaboration-time parameter sanity.
  generate
    if (MAN_WIDTH < 2) begin : g_bad_man
      $error("negf_pipe: mantissa must be at least 2 bits wide");
    end
    if (LATENCY < 0 || LATENCY > 8) begin : g_bad_lat
      $error("negf_pipe: LATENCY must be in 0..8");
    end
  endgenerate

  // ------------------------------------------------------------------
  // Sign function, computed once before the first stage.
  // ------------------------------------------------------------------
  logic                  in_sign;
  logic [EXP_WIDTH-1:0]  in_exp;
  logic [MAN_WIDTH-1:0]  in_man;
  logic                  new_sign;
  logic                  is_nan;
  logic [DATA_WIDTH-1:0] result;

  assign in_sign = ins[DATA_WIDTH-1];
  assign in_exp  = ins[DATA_WIDTH-2 -: EXP_WIDTH];
  assign in_man  = ins[MAN_WIDTH-1:0];

  // Infinity has a zero mantissa and is therefore never a NaN.
  assign is_nan  = (&in_exp) & (|in_man);

  always_comb begin
    new_sign = in_sign;
    case (sign_op_e'(ins_op))
      OP_PASS: new_sign = in_sign;
      OP_NEG:  new_sign = ~in_sign;
      OP_ABS:  new_sign = 1'b0;
      OP_NABS: new_sign = 1'b1;
      default: new_sign = in_sign;
    endcase
  end

  always_comb begin
    result = {new_sign, in_exp, in_man};
    // The canonical quiet NaN ignores the op entirely: sign is forced to 0.
    if (CANON_NAN && is_nan) begin
      result = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
    end
  end

  // ------------------------------------------------------------------
  // Register stages.
  // ------------------------------------------------------------------
  generate
    if (LATENCY == 0) begin : g_comb

      // Clock and reset have no function here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign outs       = result;
      assign outs_valid = ins_valid;
      assign ins_ready  = outs_ready;

    end else begin : g_pipe

      logic [DATA_WIDTH-1:0] data_q  [LATENCY];
      logic [LATENCY-1:0]    valid_q;
      logic [LATENCY-1:0]    adv;
      logic [LATENCY-1:0]    ready;
      logic [DATA_WIDTH-1:0] stg_dat [LATENCY];
      logic [LATENCY-1:0]    stg_vld;

      // Advance chain runs from the output back toward the input, so an
      // empty stage anywhere downstream lets everything upstream of it move.
      always_comb begin
        adv = '0;
        adv[LATENCY-1] = outs_ready;
        for (int k = LATENCY - 2; k >= 0; k--) begin
          adv[k] = ~valid_q[k+1] | adv[k+1];
        end
      end

      assign ready = ~valid_q | adv;

      // What each stage would take in if it loads this cycle.
      always_comb begin
        for (int k = 0; k < LATENCY; k++) begin
          stg_vld[k] = 1'b0;
          stg_dat[k] = '0;
        end
        stg_vld[0] = ins_valid;
        stg_dat[0] = result;
        for (int k = 1; k < LATENCY; k++) begin
          stg_vld[k] = valid_q[k-1];
          stg_dat[k] = data_q[k-1];
        end
      end

      // A loading stage takes its predecessor's valid bit (clearing it on a
      // bubble), but data only moves on a real transfer so an idle stage
      // keeps its last payload.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= '0;
          for (int k = 0; k < LATENCY; k++) begin
            data_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < LATENCY; k++) begin
            if (ready[k]) begin
              valid_q[k] <= stg_vld[k];
              if (stg_vld[k]) begin
                data_q[k] <= stg_dat[k];
              end
            end
          end
        end
      end

      assign outs       = data_q[LATENCY-1];
      assign outs_valid = valid_q[LATENCY-1];
      assign ins_ready  = ready[0];

    end
  endgenerate

endmodule

// File: doc/negf_pipe.md
# negf_pipe

Parametrised, elastic floating-point sign unit for dataflow circuits. Per token it applies one of four sign operations (pass, negate, absolute, negated-absolute) to an IEEE-754-style operand of configurable width. An optional canonical-NaN rewrite is available. Results pass through a configurable number of register stages under valid/ready handshaking. It sits in the arith library as the general successor to the single-cycle combinational float negate, for use where a sign operation must be retimed or must absorb backpressure.

## Interface

Parameters:
- DATA_WIDTH, 32: total operand width; sign at bit DATA_WIDTH-1.
- EXP_WIDTH, 8: exponent field width, bits [DATA_WIDTH-2 : DATA_WIDTH-1-EXP_WIDTH]. The mantissa is the remaining low bits, at least 2 bits wide.
- LATENCY, 1: number of register stages, 0..8. A value of 0 makes the block purely combinational.
- CANON_NAN, 0: when 1, any NaN result is replaced by the canonical quiet NaN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ins  in  DATA_WIDTH  operand.
- ins_op  in  2  operation: 00 pass, 01 negate, 10 abs, 11 negated-abs.
- ins_valid  in  1  operand and op valid.
- ins_ready  out  1  block accepts the token this cycle.
- outs  out  DATA_WIDTH  result.
- outs_valid  out  1  result valid.
- outs_ready  in  1  consumer accepts the result.

## Operation

- Sign function s' of input sign s: 00 gives s, 01 gives ~s, 10 gives 0, 11 gives 1. Exponent and mantissa pass through unchanged.
- NaN: the exponent field is all ones and the mantissa is nonzero.
  - With CANON_NAN=1, a NaN result becomes: sign 0, exponent all ones, mantissa MSB 1, all other mantissa bits 0. This rewrite overrides ins_op.
  - Infinities are not NaN and are never rewritten.
  - With CANON_NAN=0, NaN payload and quiet bit are preserved and only the sign is changed.
- The result is computed combinationally before stage 0. Each stage holds a data register and a valid bit. The op is not stored.
- Stage k advances when its successor can take a token:
  - adv[L-1] = outs_ready.
  - adv[k] = ~valid[k+1] | adv[k+1].
- A stage loads when it is empty or advancing: ready_k = ~valid[k] | adv[k].
- ins_ready = ready_0. A transfer happens when ins_valid & ins_ready.
- Bubbles collapse: an empty stage always accepts, even when downstream is stalled.
- outs = data[L-1]. outs_valid = valid[L-1].
- When a stage advances with no incoming token, its valid bit clears. Data registers load only on a transfer into the stage.
- Capacity is LATENCY tokens. Order is strictly preserved: no loss, no duplication.
- LATENCY=0: outs is the combinational result, outs_valid = ins_valid, ins_ready = outs_ready, and clk/rst are unused.

## Timing

- Reset asserted (rst=0): all valid bits clear and all data registers go to 0 immediately, without waiting for a clock edge.
  - Outputs during and after reset: outs_valid=0, outs=0, ins_ready=1 (all stages empty).
  - Reset mid-operation discards all in-flight tokens. The first token accepted after deassertion behaves as in an empty pipe.
- Latency: a token accepted at edge t presents on outs during the cycle after edge t+LATENCY-1, i.e. LATENCY cycles later.
  - This holds when no stage ahead of it is stalled.
- Throughput is one token per cycle while outs_ready=1.
- Full condition: all stages valid and outs_ready=0. Then ins_ready=0 in the same cycle.
- Full with outs_ready=1: ins_ready=1 in the same cycle. Simultaneous input and output transfer is required, and occupancy stays at LATENCY.
- Combinational paths:
  - outs_ready to ins_ready, through the adv chain.
  - No path from ins_valid to outs_valid when LATENCY≥1.
- Protocol requirements:
  - outs_valid, once asserted, stays high and outs stays stable until outs_ready=1.
  - ins_ready may drop at any cycle. A dropped ready never causes a token to be lost.

## Test plan

- Op sweep, DATA_WIDTH=32, LATENCY=1, outs_ready=1:
  - 0x3F800000 op01 → 0xBF800000.
  - 0xC0490FDB op10 → 0x40490FDB.
  - 0x00000000 op11 → 0x80000000.
  - 0xFF800000 op00 → 0xFF800000.
  - Each result is valid exactly 1 cycle after acceptance.
- NaN handling:
  - CANON_NAN=1: 0xFFC00001 op01 → 0x7FC00000; 0x7F800000 op01 → 0xFF800000 (infinity not rewritten).
  - CANON_NAN=0: 0xFFC00001 op01 → 0x7FC00001.
- Backpressure, LATENCY=3, outs_ready=0: offer tokens 1..5.
  - Exactly 3 are accepted; ins_ready=0 from the 4th offer on.
  - Raising outs_ready yields 1,2,3,4,5 in order, one per cycle, with ins_ready staying 1 under simultaneous push and pop.
- Bubble collapse, LATENCY=4: send one token, then hold outs_ready=0.
  - ins_ready stays 1 until 4 tokens are held.
  - outs stays stable while outs_valid=1.
- Async reset mid-stream, LATENCY=2: with 2 tokens in flight, pulse rst low between clock edges.
  - outs_valid=0 and outs=0 immediately.
  - After release, the next token 0x40000000 op01 emerges as 0xC0000000 after 2 cycles, with no stale output.
- Width/degenerate cases:
  - DATA_WIDTH=16, EXP_WIDTH=5, LATENCY=0: 0x3C00 op01 → 0xBC00 in the same cycle; ins_ready follows outs_ready combinationally.
  - DATA_WIDTH=64, EXP_WIDTH=11, CANON_NAN=1: 0xFFF0000000000001 op00 → 0x7FF8000000000000.
